// File: rtl/ddr4_rd_burst_ctrl.sv
// DDR4 read-burst master on the MIG ui_clk: issues BURST_LEN read commands per rd_start,
// forwards returned beats with one cycle of latency and walks a frame buffer linearly.
module ddr4_rd_burst_ctrl #(
  parameter int unsigned BASE_ADDR    = 0,
  parameter int          ADDR_W       = 29,
  parameter int unsigned ADDR_STEP    = 8,
  parameter int unsigned BURST_LEN    = 64,
  parameter int unsigned FRAME_BURSTS = 2025
) (
  input  logic              wrclk,
  input  logic              rst,
  input  logic              init_calib_complete,
  input  logic              rd_start,
  output logic              user_rd_end,
  output logic              rd_frame_end,
  output logic              rd_data_valid,
  output logic [511:0]      rd_data,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  input  logic [511:0]      app_rd_data,
  input  logic              app_rd_data_valid
);

  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam int BW = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(ADDR_STEP);
  localparam logic [ADDR_W-1:0] BURST_SPAN = ADDR_W'(BURST_LEN * ADDR_STEP);
  localparam logic [CW-1:0]     LAST_IDX   = CW'(BURST_LEN - 1);
  localparam logic [BW-1:0]     LAST_BURST = BW'(FRAME_BURSTS - 1);

  typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     cmd_cnt;
  logic [CW-1:0]     beat_cnt;
  logic [BW-1:0]     burst_cnt;
  logic [ADDR_W-1:0] burst_addr;
  logic              accept;
  logic              last_cmd;
  logic              beat_in;
  logic              last_beat;
  logic              frame_last;

  // Handshake: a command transfers on a rising edge where app_en and app_rdy are both high;
  // app_en/app_addr hold otherwise. Read beats have no back-pressure and are taken when
  // app_rd_data_valid is high, but only while a burst is open.
  assign app_cmd    = 3'b001;
  assign accept     = app_en && app_rdy;
  assign last_cmd   = accept && (cmd_cnt == LAST_IDX);
  assign beat_in    = app_rd_data_valid && (state != IDLE);
  assign last_beat  = beat_in && (beat_cnt == LAST_IDX);
  assign frame_last = (burst_cnt == LAST_BURST);

  always_ff @(posedge wrclk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (rd_start && init_calib_complete) state_next = CMD;
      // Data can race ahead of the last command, so burst end is honoured in CMD too.
      CMD: begin
        if (last_beat)     state_next = IDLE;
        else if (last_cmd) state_next = WAIT;
      end
      WAIT: if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wrclk) begin
    if (rst) begin
      app_en        <= 1'b0;
      app_addr      <= BASE;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
      user_rd_end   <= 1'b0;
      rd_frame_end  <= 1'b0;
      cmd_cnt       <= '0;
      beat_cnt      <= '0;
      burst_cnt     <= '0;
      burst_addr    <= BASE;
    end else begin
      rd_data_valid <= beat_in;
      user_rd_end   <= last_beat;
      rd_frame_end  <= last_beat && frame_last;
      if (beat_in) rd_data <= app_rd_data;

      case (state)
        IDLE: begin
          if (state_next == CMD) begin
            app_en   <= 1'b1;
            app_addr <= burst_addr;
          end
        end
        CMD: begin
          if (accept) begin
            app_addr <= app_addr + STEP;
            cmd_cnt  <= cmd_cnt + CW'(1);
          end
          // Losing calibration parks the command stream; it resumes where it stopped.
          app_en <= init_calib_complete && !last_cmd && !last_beat;
        end
        default: app_en <= 1'b0;
      endcase

      if (last_beat) begin
        cmd_cnt  <= '0;
        beat_cnt <= '0;
        if (frame_last) begin
          burst_cnt  <= '0;
          burst_addr <= BASE;
        end else begin
          burst_cnt  <= burst_cnt + BW'(1);
          burst_addr <= burst_addr + BURST_SPAN;
        end
      end else if (beat_in) begin
        beat_cnt <= beat_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ddr4_rd_burst_ctrl.sv
// Bench for ddr4_rd_burst_ctrl: MIG command/data model, transaction-level reference of the
// frame walk, table of bursts plus hand-written corner sequences and a randomized tail.
module tb_ddr4_rd_burst_ctrl;
  localparam int BL   = 4;
  localparam int FB   = 3;
  localparam int AW   = 29;
  localparam int STEP = 8;
  localparam int BASE = 'h100;
  localparam int W    = 512;

  logic          wrclk = 1'b0;
  logic          rst = 1'b1;
  logic          init_calib_complete = 1'b0;
  logic          rd_start = 1'b0;
  logic          app_rdy = 1'b0;
  logic          app_rd_data_valid = 1'b0;
  logic [W-1:0]  app_rd_data = '0;
  logic          user_rd_end;
  logic          rd_frame_end;
  logic          rd_data_valid;
  logic [W-1:0]  rd_data;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;

  ddr4_rd_burst_ctrl #(
    .BASE_ADDR(BASE), .ADDR_W(AW), .ADDR_STEP(STEP), .BURST_LEN(BL), .FRAME_BURSTS(FB)
  ) dut (
    .wrclk(wrclk), .rst(rst), .init_calib_complete(init_calib_complete), .rd_start(rd_start),
    .user_rd_end(user_rd_end), .rd_frame_end(rd_frame_end), .rd_data_valid(rd_data_valid),
    .rd_data(rd_data), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_rdy(app_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
  );

  // ---------------- clock / watchdog ----------------
  always #5 wrclk = ~wrclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int lat_lo = 5;
  int lat_hi = 5;
  logic stray_req = 1'b0;

  typedef struct { int due; logic [W-1:0] data; } ret_t;
  ret_t pend_q[$];
  logic [W-1:0] exp_q[$];
  logic [1:0]   flag_q[$];

  int ref_burst = 0;
  int ref_cmd = 0;
  int ref_beat = 0;
  int n_acc = 0;
  int n_end = 0;
  int n_fe = 0;
  int end_cyc = -100;
  int gap_last = -1;
  logic [AW-1:0] last_start = '0;
  logic prev_calib = 1'b1;
  logic prev_hold = 1'b0;
  logic prev_en = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  ret_t r;
  int due;
  logic [W-1:0] d;
  logic [1:0] f;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] x;
    for (int i = 0; i < W / 32; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  // ---------------- MIG model + scoreboard (sampled 1 ns after the falling edge) ----------------
  always begin
    @(negedge wrclk);
    #1;
    cyc++;

    if (rd_data_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_rd_data_valid: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        d = exp_q.pop_front();
        f = flag_q.pop_front();
        check("rd_data", rd_data, d);
        check("user_rd_end", W'(user_rd_end), W'(f[1]));
        check("rd_frame_end", W'(rd_frame_end), W'(f[0]));
      end
    end else begin
      check("end_without_beat", W'({user_rd_end, rd_frame_end}), W'(2'b00));
    end
    check("app_cmd", W'(app_cmd), W'(3'b001));
    if (!prev_calib) check("app_en_calib_low", W'(app_en), W'(1'b0));
    if (prev_hold) begin
      check("hold_app_en", W'(app_en), W'(1'b1));
      check("hold_app_addr", W'(app_addr), W'(prev_addr));
    end
    if (user_rd_end) begin
      n_end++;
      end_cyc = cyc;
    end
    if (rd_frame_end) n_fe++;
    if (app_en && !prev_en) gap_last = cyc - end_cyc;

    if (rst) begin
      ref_burst = 0;
      ref_cmd = 0;
      ref_beat = 0;
      exp_q.delete();
      flag_q.delete();
    end

    // Command accepted at the coming rising edge.
    if (app_en && app_rdy) begin
      due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (pend_q.size() > 0 && due <= pend_q[pend_q.size()-1].due) due = pend_q[pend_q.size()-1].due + 1;
      pend_q.push_back('{due, rand_data()});
      if (!rst) begin
        n_acc++;
        if (ref_cmd == 0) last_start = app_addr;
        check("cmd_in_burst", W'(ref_cmd < BL), W'(1'b1));
        check("cmd_addr", W'(app_addr), W'(AW'(BASE + (ref_burst * BL + ref_cmd) * STEP)));
        ref_cmd++;
      end
    end

    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      r = pend_q.pop_front();
      app_rd_data_valid = 1'b1;
      app_rd_data = r.data;
      if (!rst && ref_beat < ref_cmd) begin
        exp_q.push_back(r.data);
        flag_q.push_back({ref_beat == BL - 1, (ref_beat == BL - 1) && (ref_burst == FB - 1)});
        ref_beat++;
        if (ref_beat == BL) begin
          ref_burst = (ref_burst + 1) % FB;
          ref_cmd = 0;
          ref_beat = 0;
        end
      end
    end else if (stray_req) begin
      app_rd_data_valid = 1'b1;
      app_rd_data = rand_data();
      stray_req = 1'b0;
    end else begin
      app_rd_data_valid = 1'b0;
      app_rd_data = rand_data();
    end

    prev_calib = init_calib_complete;
    prev_hold = app_en && !app_rdy && init_calib_complete && !rst;
    prev_addr = app_addr;
    prev_en = app_en;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge wrclk);
    case (rdy_mode)
      0:       app_rdy = 1'b1;
      1:       app_rdy = (cyc % 3 == 0);
      2:       app_rdy = 1'($urandom_range(1, 0));
      default: app_rdy = 1'b0;
    endcase
  endtask

  task automatic wait_ends(input int target, input int budget);
    int n;
    n = 0;
    while (n_end < target && n < budget) begin
      tick();
      n++;
    end
    check("burst_end_in_time", W'(n_end >= target), W'(1'b1));
  endtask

  task automatic wait_quiet();
    int q;
    int n;
    q = 0;
    n = 0;
    while (q < 4 && n < 500) begin
      tick();
      n++;
      if (!app_en && ref_cmd == 0 && pend_q.size() == 0 && !rd_data_valid) q++;
      else q = 0;
    end
    check("quiet_in_time", W'(q >= 4), W'(1'b1));
  endtask

  task automatic run_burst(input int mode);
    int e0;
    e0 = n_end;
    rdy_mode = mode;
    tick();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    wait_ends(e0 + 1, 300);
  endtask

  task automatic wait_accepts(input int target);
    int n;
    n = 0;
    while (n_acc < target && n < 100) begin
      tick();
      n++;
    end
    check("accepts_in_time", W'(n_acc >= target), W'(1'b1));
  endtask

  typedef struct { int mode; int lo; int hi; int exp_start; int exp_fe; } vec_t;
  vec_t vecs[6];

  initial begin
    int a0;
    int e0;
    int f0;
    vecs[0] = '{0, 5, 5, 'h100, 0};
    vecs[1] = '{1, 5, 5, 'h120, 0};
    vecs[2] = '{2, 1, 8, 'h140, 1};
    vecs[3] = '{0, 5, 5, 'h100, 0};
    vecs[4] = '{2, 1, 8, 'h120, 0};
    vecs[5] = '{1, 2, 6, 'h140, 1};

    // Reset values.
    repeat (3) tick();
    check("rst_app_en", W'(app_en), W'(1'b0));
    check("rst_app_cmd", W'(app_cmd), W'(3'b001));
    check("rst_app_addr", W'(app_addr), W'(BASE));
    check("rst_rd_data_valid", W'(rd_data_valid), W'(1'b0));
    check("rst_rd_data", rd_data, '0);
    check("rst_user_rd_end", W'(user_rd_end), W'(1'b0));
    check("rst_rd_frame_end", W'(rd_frame_end), W'(1'b0));
    rst = 1'b0;

    // Stray beat in IDLE must be dropped.
    stray_req = 1'b1;
    repeat (4) tick();

    // Calibration low blocks rd_start; raising it starts at BASE on the next cycle.
    rd_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("calib_low_no_cmd", W'(app_en), W'(1'b0));
    end
    init_calib_complete = 1'b1;
    tick();
    check("calib_up_app_en", W'(app_en), W'(1'b1));
    check("calib_up_app_addr", W'(app_addr), W'(BASE));
    rd_start = 1'b0;
    wait_ends(n_end + 1, 300);
    wait_quiet();

    // Reset after two accepted commands.
    lat_lo = 5;
    lat_hi = 5;
    rdy_mode = 0;
    a0 = n_acc;
    e0 = n_end;
    tick();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    wait_accepts(a0 + 2);
    rdy_mode = 3;
    app_rdy = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_app_en", W'(app_en), W'(1'b0));
    check("midrst_app_addr", W'(app_addr), W'(BASE));
    repeat (12) tick();
    check("midrst_no_end", W'(n_end - e0), W'(0));
    run_burst(0);
    wait_quiet();
    check("midrst_restart_addr", W'(last_start), W'(BASE));

    // Table of bursts from a clean frame start.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      lat_lo = vecs[i].lo;
      lat_hi = vecs[i].hi;
      a0 = n_acc;
      f0 = n_fe;
      run_burst(vecs[i].mode);
      wait_quiet();
      check("vec_start_addr", W'(last_start), W'(AW'(vecs[i].exp_start)));
      check("vec_accepts", W'(n_acc - a0), W'(BL));
      check("vec_frame_end", W'(n_fe - f0), W'(vecs[i].exp_fe));
    end

    // rd_start held high: one IDLE cycle between bursts.
    lat_lo = 5;
    lat_hi = 5;
    rdy_mode = 0;
    e0 = n_end;
    rd_start = 1'b1;
    wait_ends(e0 + 2, 400);
    check("held_start_gap", W'(gap_last), W'(1));
    rd_start = 1'b0;
    wait_quiet();

    // rd_start pulses inside a burst are ignored.
    lat_lo = 3;
    lat_hi = 7;
    a0 = n_acc;
    e0 = n_end;
    rdy_mode = 2;
    tick();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    wait_accepts(a0 + 1);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    wait_quiet();
    check("pulse_single_burst", W'(n_end - e0), W'(1));
    check("pulse_accepts", W'(n_acc - a0), W'(BL));

    // Calibration drop during CMD.
    a0 = n_acc;
    rdy_mode = 2;
    tick();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    wait_accepts(a0 + 1);
    init_calib_complete = 1'b0;
    repeat (4) tick();
    init_calib_complete = 1'b1;
    wait_quiet();
    check("calib_drop_accepts", W'(n_acc - a0), W'(BL));

    // Randomized bursts against the reference walk.
    for (int i = 0; i < 20; i++) begin
      lat_lo = int'($urandom_range(3, 1));
      lat_hi = lat_lo + int'($urandom_range(6, 0));
      run_burst(int'($urandom_range(2, 0)));
      repeat ($urandom_range(3, 0)) tick();
    end
    wait_quiet();
    check("exp_q_drained", W'(exp_q.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr4_rd_burst_ctrl.md
Name: ddr4_rd_burst_ctrl

Overview:
- DDR4 read master that sits directly upstream of the HDMI frame buffer in the wrclk (MIG ui_clk) domain.
- On each rd_start request it issues one burst of BURST_LEN read commands to the MIG app interface and forwards the returned 512-bit beats as rd_data/rd_data_valid.
- It pulses user_rd_end on the last beat of the burst.
- The read address walks linearly through one frame buffer and wraps to BASE_ADDR at frame end.

Parameters:
- BASE_ADDR, 0, first DDR address of the frame buffer (app_addr units).
- ADDR_W, 29, app_addr width.
- ADDR_STEP, 8, address increment per 512-bit beat (8 x 64-bit DDR words).
- BURST_LEN, 64, read commands / data beats per burst (power of two, >=2).
- FRAME_BURSTS, 2025, bursts per frame (1920x1080x32b / 512b / 64).

Ports:
- wrclk  in  1  MIG ui_clk; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- init_calib_complete  in  1  MIG calibration done; no commands are issued while low.
- rd_start  in  1  burst request from the HDMI buffer; sampled only in IDLE.
- user_rd_end  out  1  one-cycle pulse coincident with the last rd_data_valid of a burst.
- rd_frame_end  out  1  one-cycle pulse coincident with user_rd_end of the last burst of a frame.
- rd_data_valid  out  1  rd_data qualifier.
- rd_data  out  512  read beat to the HDMI buffer.
- app_en  out  1  MIG command valid.
- app_cmd  out  3  MIG command; constant 3'b001 (read).
- app_addr  out  ADDR_W  MIG command address.
- app_rdy  in  1  MIG command accept.
- app_rd_data  in  512  MIG read data.
- app_rd_data_valid  in  1  MIG read data valid.

Behaviour:
- Reset values: app_en=0, app_cmd=3'b001, app_addr=BASE_ADDR, rd_data_valid=0, rd_data=0, user_rd_end=0, rd_frame_end=0. Internal state: state=IDLE, burst_addr=BASE_ADDR, all counters=0.
- FSM has three states: IDLE, CMD, WAIT.
- IDLE:
  - Transition to CMD when rd_start=1 and init_calib_complete=1.
  - On entry to CMD, app_addr is loaded from burst_addr.
  - rd_start in any other state, or while calibration is low, is ignored; no pending request is stored.
- CMD:
  - app_en=1 (registered). Command accepted when app_en & app_rdy.
  - On each accept: app_addr += ADDR_STEP and cmd_cnt++.
  - When app_rdy=0, app_en and app_addr hold their values.
  - On the BURST_LEN-th accept, app_en is deasserted in the next cycle and the FSM moves to WAIT.
- Data return (CMD or WAIT):
  - Returned data is counted in both CMD and WAIT, because data may return before all commands are issued.
  - rd_data/rd_data_valid are app_rd_data/app_rd_data_valid registered once, giving 1-cycle latency.
  - Forwarding is gated: valid only when the FSM is not in IDLE.
  - beat_cnt increments on each app_rd_data_valid.
- Burst end:
  - On the BURST_LEN-th beat, user_rd_end=1 in the same output cycle as that beat's rd_data_valid, and the FSM returns to IDLE.
  - burst_addr += BURST_LEN*ADDR_STEP.
  - burst_cnt++.
  - If burst_cnt was FRAME_BURSTS-1: burst_cnt=0, burst_addr=BASE_ADDR, and rd_frame_end pulses together with user_rd_end.
- Minimum gap: at least one IDLE cycle between bursts, so rd_start held high restarts one cycle after user_rd_end.
- Width rules:
  - cmd_cnt and beat_cnt are clog2(BURST_LEN)+1 bits.
  - burst_cnt is clog2(FRAME_BURSTS) bits.
  - Address arithmetic is modulo 2^ADDR_W (no overflow flag).
- Stray data: app_rd_data_valid received in IDLE (e.g. after reset) is dropped and not counted.
- Reset mid-burst: every output and counter returns to its reset value in the cycle after rst is sampled high. In-flight MIG data arriving afterwards is dropped by the IDLE gate. The next rd_start reads from BASE_ADDR.
- Calibration drop: if init_calib_complete deasserts during CMD, app_en is forced to 0 and the FSM holds until calibration returns, then continues the burst.

Test Plan:
- Basic burst (BURST_LEN=4, FRAME_BURSTS=3, BASE_ADDR=0x100, app_rdy=1, model returns data 5 cycles after each accept) -> app_addr sequence 0x100/0x108/0x110/0x118; exactly 4 rd_data_valid in order; user_rd_end on beat 4 only.
- Back-pressure (app_rdy toggles 1,0,0,1,...) -> app_en and app_addr stable while rdy=0; exactly 4 accepted commands; no duplicated or skipped address.
- Frame wrap (3 consecutive bursts) -> burst start addresses 0x100, 0x120, 0x140; rd_frame_end together with user_rd_end on burst 3; 4th burst starts at 0x100.
- rd_start held high continuously -> bursts separated by exactly one IDLE cycle; a pulse on rd_start during CMD/WAIT produces no extra burst.
- Reset after 2 accepted commands, model still returns 2 beats -> rd_data_valid stays 0, no user_rd_end; next rd_start reads from 0x100.
- init_calib_complete=0 with rd_start=1 -> app_en stays 0; raise calib -> burst starts next cycle at BASE_ADDR.
